mul_booth_csa_seq: RTL and testbench
====================================

# mul_booth_csa_seq

Sequential radix-4 Booth partial-product generator and carry-save accumulator for the 16x16 two's-complement multiplier. It accepts a signed operand pair and retires one Booth digit per cycle into a 3:2 carry-save accumulator. It presents a redundant (sum, carry) pair whose modulo-2^(2·DW) sum is the product. Sits directly upstream of the 32-bit carry-lookahead final adder, which consumes sum and carry with ci = 0.

## Interface
- DW, 16, operand width; must be even; product width PW = 2·DW; digit count ND = DW/2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  operand pair valid
- in_rdy  out  1  block can accept operands
- a  in  DW  multiplicand, signed
- b  in  DW  multiplier, signed
- out_vld  out  1  sum/carry valid
- out_rdy  in  1  downstream accepts result
- sum  out  PW  redundant result, sum vector
- carry  out  PW  redundant result, carry vector (already weight-aligned, add directly)

## Operation
- States: IDLE, ACC, FIX, OUT. Reset -> IDLE; in_rdy = 1, out_vld = 0, sum = carry = 0.
- IDLE: in_rdy = 1. On in_vld: latch a, b; clear sum, carry, corr; digit counter cnt = 0; go ACC.
- ACC: digit i = cnt uses b[2i+1], b[2i], b[2i-1] (b[-1] = 0). d = −2·b[2i+1] + b[2i] + b[2i−1].
- Magnitude m = |d|·a, sign-extended to PW.
  - d = 0 (000 or 111): pp = 0, neg = 0.
  - d > 0: pp = m << 2i.
  - d < 0: pp = (~m) << 2i (zeros shifted in), corr[2i] = 1.
- Each ACC edge: (sum, carry) <= CSA(sum, carry, pp), where sum = a^b^c and carry = maj(a, b, c) << 1 with bit 0 = 0; cnt++.
- After cnt = ND−1 go FIX.
- FIX: (sum, carry) <= CSA(sum, carry, corr); go OUT.
- OUT: out_vld = 1; sum and carry held stable. On out_rdy go IDLE.
- in_rdy = 0 in ACC, FIX and OUT; in_vld is ignored there. No back-to-back accept in the OUT cycle.
- Arithmetic is modulo 2^PW; overflow beyond bit PW−1 is discarded. Invariant: (sum + carry) mod 2^PW = a·b (signed) whenever out_vld = 1.
- Reset mid-operation: immediate return to IDLE with outputs zeroed; the in-flight operation is lost.

## Timing
- Edge E0: in_vld & in_rdy accepted.
- Edges E1..E8: digits 0..7 accumulated.
- Edge E9: FIX compression; out_vld high from E9 until the edge where out_rdy = 1.
- Latency: 9 cycles from acceptance to out_vld. Minimum throughput: 1 product per 11 cycles (IDLE cycle included).
- out_rdy held low: sum, carry and out_vld stay constant indefinitely.
- out_rdy already high on entry to OUT: handshake completes on the first OUT edge.
- All outputs are registered or decoded from state only; no input-to-output combinational path.

## Structure
- Shared package (mul_pkg): state encoding (IDLE/ACC/FIX/OUT), DW/PW/ND localparams, Booth digit encoding (zero, ±1, ±2 select and neg flag).
- One sub-module: csa32, a PW-bit 3:2 compressor. A single instance is used, with its third operand muxed between pp (ACC) and corr (FIX).
- Booth digit select and pp formation stay inline.

## Test plan
- a = 0x0003, b = 0x0005 -> out_vld 9 cycles after accept; sum + carry = 0x0000000F.
- a = 0x8000, b = 0x8000 -> sum + carry = 0x40000000.
- a = 0x7FFF, b = 0x7FFF -> 0x3FFF0001. a = 0x8000, b = 0x7FFF -> 0xC0008000.
- a = 0xFFFF, b = 0x0000 -> 0x00000000; a = 0x1234, b = 0xFFFF -> 0xFFFFEDCC.
- out_rdy held low 20 cycles after out_vld -> outputs stable, in_rdy = 0, and a new in_vld is ignored. Raise out_rdy -> IDLE next edge, in_rdy = 1.
- rst_n pulsed low at cycle 4 of ACC -> out_vld = 0, sum = carry = 0, in_rdy = 1 immediately. The next operation a = 0xFFFE, b = 0x0003 yields 0xFFFFFFFA.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth / carry-save multiplier:
// sizes, controller state encoding and Booth digit decode.
package mul_pkg;

    localparam int DW = 16;
    localparam int PW = 2 * DW;
    localparam int ND = DW / 2;
    localparam int CW = $clog2(ND);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIX,
        OUT
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_ONE,
        SEL_TWO
    } sel_t;

    typedef struct packed {
        sel_t sel;
        logic neg;
    } booth_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}; value is -2*t[2] + t[1] + t[0].
    function automatic booth_t booth_decode(input logic [2:0] t);
        booth_t d;
        case (t)
            3'b001, 3'b010: d = '{sel: SEL_ONE,  neg: 1'b0};
            3'b011:         d = '{sel: SEL_TWO,  neg: 1'b0};
            3'b100:         d = '{sel: SEL_TWO,  neg: 1'b1};
            3'b101, 3'b110: d = '{sel: SEL_ONE,  neg: 1'b1};
            default:        d = '{sel: SEL_ZERO, neg: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/csa32.sv
// PW-bit 3:2 carry-save compressor; the carry output is already shifted to its
// true weight so s + c == x + y + z (mod 2^W).
module csa32
    import mul_pkg::*;
#(
    parameter int W = PW
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-1:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x & y) | (x & z) | (y & z);
    // The majority out of the top bit has weight 2^W and is dropped.
    assign c   = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/mul_booth_csa_seq.sv
// Sequential radix-4 Booth multiplier front end: one Booth digit per cycle into a
// carry-save accumulator, followed by a single pass that folds in the +1 corrections.
module mul_booth_csa_seq
    import mul_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [PW-1:0] sum,
    output logic [PW-1:0] carry
);

    state_t        state, state_nxt;
    logic [DW-1:0] a_q;
    logic [DW:0]   bx_q;      // {b, 1'b0}: bit 0 plays the role of b[-1]
    logic [PW-1:0] corr_q;
    logic [CW-1:0] cnt_q;

    logic [CW:0]   sh;
    booth_t        digit;
    logic [PW-1:0] a_ext, m, pp, z, corr_bit, csa_s, csa_c;

    assign sh    = {cnt_q, 1'b0};
    assign a_ext = {{(PW-DW){a_q[DW-1]}}, a_q};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        digit    = booth_decode(bx_q[sh +: 3]);
        m        = '0;
        pp       = '0;
        corr_bit = '0;
        case (digit.sel)
            SEL_ONE: m = a_ext;
            SEL_TWO: m = a_ext << 1;
            default: m = '0;
        endcase
        // Negative digits add the one's complement here; the +1 lands in corr.
        if (digit.sel != SEL_ZERO) begin
            pp = digit.neg ? (~m) << sh : m << sh;
        end
        if (digit.neg) begin
            corr_bit = PW'(1) << sh;
        end
        z = (state == FIX) ? corr_q : pp;
    end

    csa32 #(.W(PW)) u_csa (
        .x (sum),
        .y (carry),
        .z (z),
        .s (csa_s),
        .c (csa_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_vld)                 state_nxt = ACC;
            ACC:  if (cnt_q == CW'(ND - 1))   state_nxt = FIX;
            FIX:                              state_nxt = OUT;
            OUT:  if (out_rdy)                state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    assign in_rdy  = (state == IDLE);
    assign out_vld = (state == OUT);

    // NOTE: registered state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            bx_q   <= '0;
            corr_q <= '0;
            cnt_q  <= '0;
            sum    <= '0;
            carry  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_vld) begin
                    a_q    <= a;
                    bx_q   <= {b, 1'b0};
                    corr_q <= '0;
                    cnt_q  <= '0;
                    sum    <= '0;
                    carry  <= '0;
                end
                ACC: begin
                    sum    <= csa_s;
                    carry  <= csa_c;
                    corr_q <= corr_q | corr_bit;
                    cnt_q  <= cnt_q + CW'(1);
                end
                FIX: begin
                    sum   <= csa_s;
                    carry <= csa_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_booth_csa_seq.sv
// Directed bench for mul_booth_csa_seq: products, latency, output stall,
// early out_rdy with back-to-back operations, and reset during accumulation.
`timescale 1ns/1ps
module tb_mul_booth_csa_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] sum;
    logic [31:0] carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_booth_csa_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .a       (a),
        .b       (b),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .sum     (sum),
        .carry   (carry)
    );

    // Present one operand pair for a single edge; returns at the negedge after it.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        a      = av;
        b      = bv;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    // Counts negedges until out_vld, bounded so a dead DUT cannot hang the run.
    task automatic wait_out(output int cycles, output bit timeout);
        cycles = 0;
        while (!out_vld && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        timeout = !out_vld;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        a       = '0;
        b       = '0;
        #3;
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || sum !== 32'h0 || carry !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: in_rdy=%b out_vld=%b sum=%h carry=%h, want 1 0 0 0",
                     in_rdy, out_vld, sum, carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_products();
        logic [15:0] av  [8] = '{16'h0003, 16'h8000, 16'h7FFF, 16'h8000,
                                 16'hFFFF, 16'h1234, 16'h0007, 16'h0100};
        logic [15:0] bv  [8] = '{16'h0005, 16'h8000, 16'h7FFF, 16'h7FFF,
                                 16'h0000, 16'hFFFF, 16'hFFFD, 16'h0100};
        logic [31:0] exp [8] = '{32'h0000000F, 32'h40000000, 32'h3FFF0001, 32'hC0008000,
                                 32'h00000000, 32'hFFFFEDCC, 32'hFFFFFFEB, 32'h00010000};
        int cyc;
        bit to;
        logic [31:0] prod;
        for (int i = 0; i < 8; i++) begin
            start_op(av[i], bv[i]);
            wait_out(cyc, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL product_timeout[%0d]: out_vld=%b after %0d cycles, want 1", i, out_vld, cyc);
            end
            checks++;
            if (cyc != 9) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d cycles, want 9", i, cyc);
            end
            prod = sum + carry;
            checks++;
            if (prod !== exp[i]) begin
                errors++;
                $display("FAIL product[%0d] %h*%h: got %h, want %h", i, av[i], bv[i], prod, exp[i]);
            end
            checks++;
            if (in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL busy_rdy[%0d]: in_rdy=%b, want 0", i, in_rdy);
            end
            out_rdy = 1'b1;
            @(negedge clk);
            out_rdy = 1'b0;
            checks++;
            if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
                errors++;
                $display("FAIL release[%0d]: in_rdy=%b out_vld=%b, want 1 0", i, in_rdy, out_vld);
            end
        end
    endtask

    task automatic test_stall();
        int cyc;
        bit to;
        logic [31:0] s0, c0;
        int bad = 0;
        start_op(16'h7FFF, 16'h7FFF);
        wait_out(cyc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL stall_timeout: out_vld=%b, want 1", out_vld);
        end
        s0 = sum;
        c0 = carry;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                a      = 16'h0002;
                b      = 16'h0002;
                in_vld = 1'b1;
            end
            if (k == 15) in_vld = 1'b0;
            @(negedge clk);
            if (sum !== s0 || carry !== c0 || out_vld !== 1'b1 || in_rdy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles (last sum=%h carry=%h vld=%b rdy=%b), want 0",
                     bad, sum, carry, out_vld, in_rdy);
        end
        checks++;
        if (sum + carry !== 32'h3FFF0001) begin
            errors++;
            $display("FAIL stall_product: got %h, want 3fff0001", sum + carry);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: in_rdy=%b out_vld=%b, want 1 0", in_rdy, out_vld);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        out_rdy = 1'b1;
        start_op(16'h0003, 16'h0005);
        wait_out(cyc, to);
        checks++;
        if (to || cyc != 9 || sum + carry !== 32'h0000000F) begin
            errors++;
            $display("FAIL early_rdy_first: timeout=%b cycles=%0d prod=%h, want 0 9 0000000f",
                     to, cyc, sum + carry);
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL early_rdy_release: out_vld=%b in_rdy=%b, want 0 1", out_vld, in_rdy);
        end
        // start_op waits one more negedge, so this accept lands on the first IDLE edge.
        a      = 16'h7FFF;
        b      = 16'h8000;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        wait_out(cyc, to);
        checks++;
        if (to || cyc != 9 || sum + carry !== 32'hC0008000) begin
            errors++;
            $display("FAIL back_to_back: timeout=%b cycles=%0d prod=%h, want 0 9 c0008000",
                     to, cyc, sum + carry);
        end
        @(negedge clk);
        out_rdy = 1'b0;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_idle: in_rdy=%b, want 1", in_rdy);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        bit to;
        start_op(16'h1234, 16'h5678);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || sum !== 32'h0 || carry !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: out_vld=%b in_rdy=%b sum=%h carry=%h, want 0 1 0 0",
                     out_vld, in_rdy, sum, carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'hFFFE, 16'h0003);
        wait_out(cyc, to);
        checks++;
        if (to || sum + carry !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL after_reset_product: timeout=%b prod=%h, want 0 fffffffa", to, sum + carry);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_products();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
